// File: rtl/vga_xfer_pkg.sv
// Shared types and helpers for the VGA frame transfer engine.
// Holds the sequencer state encoding, mode constants and lane math.
package vga_xfer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } xfer_state_t;

    localparam logic MODE_PACKED = 1'b0;
    localparam logic MODE_UNPACK = 1'b1;

    function automatic int calc_lanes(input int data_w, input int pix_w);
        return data_w / pix_w;
    endfunction

endpackage

// File: rtl/vga_lane_mux.sv
// Lane select for framebuffer write data.
// Packed mode passes the word; unpacked mode zero-extends one pixel.
module vga_lane_mux
    import vga_xfer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PIX_W  = 8,
    parameter int LANE_W = 2
) (
    input  logic              mode,
    input  logic [DATA_W-1:0] word,
    input  logic [LANE_W-1:0] lane,
    output logic [DATA_W-1:0] data
);

    // Pick the full word or the little-endian pixel at the current lane
    always_comb begin
        data = '0;
        if (mode == MODE_UNPACK) begin
            data[PIX_W-1:0] = word[int'(lane)*PIX_W +: PIX_W];
        end else begin
            data = word;
        end
    end

endmodule

// File: rtl/vga_frame_transfer.sv
// DMA-style copy from data memory into the VGA framebuffer.
// Read, wait one cycle for data, then write one or more entries per word.
module vga_frame_transfer
    import vga_xfer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              mode_unpack,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] word_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);

    localparam int LANES  = calc_lanes(DATA_W, PIX_W);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    xfer_state_t       state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              last_lane;

    // Packed words occupy a single lane
    assign last_lane = (mode_q == MODE_UNPACK)
                     ? (lane_q == LANE_W'(LANES - 1)) : 1'b1;

    // Next-state and datapath updates; abort overrides any busy state
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        word_d  = word_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode_unpack;
                    src_d   = src_base;
                    dst_d   = dst_base;
                    cnt_d   = word_count;
                    idx_d   = '0;
                    lane_d  = '0;
                    state_d = (word_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                word_d  = rd_data;
                lane_d  = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_ready) begin
                    dst_d = dst_q + ADDR_W'(1);
                    if (!last_lane) begin
                        lane_d = lane_q + LANE_W'(1);
                    end else if (idx_q == cnt_q - ADDR_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
        end
    end

    assign rd_en   = (state_q == S_READ);
    assign wr_en   = (state_q == S_WRITE);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign rd_addr = src_q + idx_q;
    assign wr_addr = dst_q;

    vga_lane_mux #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W),
        .LANE_W (LANE_W)
    ) u_lane_mux (
        .mode (mode_q),
        .word (word_q),
        .lane (lane_q),
        .data (wr_data)
    );

endmodule
